// File: rtl/player_input_conditioner.sv
// Board key/switch front end: polarity, sync, debounce, press pulses.
// Optional auto-repeat on held buttons: define PLAYER_INPUT_AUTOREPEAT_EN.
module player_input_conditioner #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BTNS_PER_PLAYER = 2,
  parameter int SW_PER_PLAYER   = 4,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] raw_keys,
  input  logic [NUM_PLAYERS*SW_PER_PLAYER-1:0]   raw_sw,
  output logic [NUM_PLAYERS*(BTNS_PER_PLAYER+SW_PER_PLAYER)-1:0] controls,
  output logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] btn_press,
  output logic [NUM_PLAYERS-1:0]                 ctrl_changed,
  output logic                                   reset_req
);

  localparam int P  = NUM_PLAYERS;
  localparam int B  = BTNS_PER_PLAYER;
  localparam int S  = SW_PER_PLAYER;
  localparam int W  = B + S;
  localparam int NB = P * W;
  localparam int NK = P * B;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic KAL = 1'(KEY_ACTIVE_LOW);

  // All inputs are handled in controls bit order from entry onward.
  logic [NB-1:0] ent;
  logic [NB-1:0] s1_q;
  logic [NB-1:0] s2_q;
  logic [NB-1:0] stb_q;
  logic [NB-1:0] stb_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NK-1:0] press_q;
  logic [NK-1:0] press_d;
  logic [P-1:0]  chg_q;
  logic [P-1:0]  chg_d;

  for (genvar p = 0; p < P; p++) begin : g_pl
    for (genvar b = 0; b < B; b++) begin : g_btn
      assign ent[p*W+W-1-b] = raw_keys[p*B+b] ^ KAL;
    end
    for (genvar s = 0; s < S; s++) begin : g_sw
      assign ent[p*W+s] = raw_sw[p*S+s];
    end
  end

  // Count consecutive disagreeing samples; accept after DEBOUNCE_CYCLES.
  always_comb begin
    stb_d = stb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stb_d[i] = ~stb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

`ifdef PLAYER_INPUT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(RMAX + 1);

  logic [HW-1:0] hold_q [NK];
  logic [HW-1:0] hold_d [NK];
  logic [NK-1:0] rep_q;
  logic [NK-1:0] rep_d;
  logic [NK-1:0] rpt;

  // Hold timer restarts on press; first threshold is the delay,
  // later thresholds the period. Any cycle not held clears it.
  always_comb begin
    rpt   = '0;
    rep_d = rep_q;
    for (int p = 0; p < P; p++) begin
      for (int b = 0; b < B; b++) begin
        hold_d[p*B+b] = hold_q[p*B+b];
        if (!(stb_q[p*W+W-1-b] && stb_d[p*W+W-1-b])) begin
          hold_d[p*B+b] = '0;
          rep_d[p*B+b]  = 1'b0;
        end else if (hold_q[p*B+b] + HW'(1) ==
                     (rep_q[p*B+b] ? HW'(REPEAT_PERIOD)
                                   : HW'(REPEAT_DELAY))) begin
          rpt[p*B+b]    = 1'b1;
          hold_d[p*B+b] = '0;
          rep_d[p*B+b]  = 1'b1;
        end else begin
          hold_d[p*B+b] = hold_q[p*B+b] + HW'(1);
        end
      end
    end
  end

  // Hold timer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q <= '0;
      for (int k = 0; k < NK; k++) hold_q[k] <= '0;
    end else begin
      rep_q <= rep_d;
      for (int k = 0; k < NK; k++) hold_q[k] <= hold_d[k];
    end
  end
`endif

  // Press pulses on accepted rises; change strobe per player slice.
  always_comb begin
    press_d = '0;
    chg_d   = '0;
    for (int p = 0; p < P; p++) begin
      chg_d[p] = |(stb_d[p*W +: W] ^ stb_q[p*W +: W]);
      for (int b = 0; b < B; b++) begin
        press_d[p*B+b] = stb_d[p*W+W-1-b] & ~stb_q[p*W+W-1-b];
      end
    end
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
    press_d = press_d | rpt;
`endif
  end

  // Synchroniser, debounce state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      stb_q   <= '0;
      press_q <= '0;
      chg_q   <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= ent;
      s2_q    <= s1_q;
      stb_q   <= stb_d;
      press_q <= press_d;
      chg_q   <= chg_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign controls     = stb_q;
  assign btn_press    = press_q;
  assign ctrl_changed = chg_q;
  assign reset_req    = stb_q[W-1];

endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner: directed steps plus random
// toggling, checked against a history-window reference model.
module tb_player_input_conditioner;

  localparam int P  = 3;
  localparam int B  = 2;
  localparam int S  = 4;
  localparam int W  = B + S;
  localparam int NB = P * W;
  localparam int NK = P * B;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NK-1:0]  raw_keys;
  logic [P*S-1:0] raw_sw;
  logic [NB-1:0]  controls;
  logic [NK-1:0]  btn_press;
  logic [P-1:0]   ctrl_changed;
  logic           reset_req;

  player_input_conditioner #(
    .NUM_PLAYERS(P), .BTNS_PER_PLAYER(B), .SW_PER_PLAYER(S),
    .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .raw_keys(raw_keys), .raw_sw(raw_sw),
    .controls(controls), .btn_press(btn_press),
    .ctrl_changed(ctrl_changed), .reset_req(reset_req)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: per input, the asserted value seen at each of the last edges.
  bit hist [NB][D+2];
  bit mstb [NB];
  int held [NK];
  logic [NB-1:0] x_ctrl;
  logic [NK-1:0] x_press;
  logic [P-1:0]  x_chg;
  logic          x_rr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit e [NB];
    bit fl [NB];
    bit agree;
    x_press = '0;
    x_chg   = '0;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        mstb[i] = 0;
        for (int j = 0; j < D + 2; j++) hist[i][j] = 0;
      end
      for (int k = 0; k < NK; k++) held[k] = -1;
      x_ctrl = '0;
      x_rr   = 1'b0;
      return;
    end
    for (int p = 0; p < P; p++) begin
      for (int b = 0; b < B; b++) e[p*W+W-1-b] = !raw_keys[p*B+b];
      for (int s = 0; s < S; s++) e[p*W+s] = raw_sw[p*S+s];
    end
    for (int i = 0; i < NB; i++) begin
      for (int j = D + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = e[i];
      // Accepted when the D oldest synchronised samples all disagree.
      agree = 0;
      for (int j = 2; j < D + 2; j++)
        if (hist[i][j] == mstb[i]) agree = 1;
      fl[i] = !agree;
      if (fl[i]) begin
        mstb[i] = !mstb[i];
        x_chg[i / W] = 1'b1;
      end
    end
    for (int p = 0; p < P; p++) begin
      for (int b = 0; b < B; b++) begin
        int i;
        int k;
        i = p*W + W - 1 - b;
        k = p*B + b;
        if (mstb[i] && fl[i]) begin
          x_press[k] = 1'b1;
          held[k] = 0;
        end else if (!mstb[i]) begin
          held[k] = -1;
        end else if (held[k] >= 0) begin
          held[k]++;
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
          if (held[k] == RD ||
              (held[k] > RD && (held[k] - RD) % RP == 0))
            x_press[k] = 1'b1;
`endif
        end
      end
    end
    for (int i = 0; i < NB; i++) x_ctrl[i] = mstb[i];
    x_rr = mstb[W-1];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("controls", 32'(controls), 32'(x_ctrl));
    chk("btn_press", 32'(btn_press), 32'(x_press));
    chk("ctrl_changed", 32'(ctrl_changed), 32'(x_chg));
    chk("reset_req", 32'(reset_req), 32'(x_rr));
  endtask

  initial begin
    rst = 1'b1;
    raw_keys = '1;
    raw_sw = '0;
    repeat (3) step();
    chk("reset_ctrl", 32'(controls), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Single press: accepted on the (D+2)th edge after sampling.
    raw_keys[0] = 1'b0;
    repeat (D + 1) step();
    chk("lat_early", 32'(controls[W-1]), 32'd0);
    step();
    chk("lat_rise", 32'(controls[W-1]), 32'd1);
    chk("lat_press", 32'(btn_press[0]), 32'd1);
    chk("lat_chg", 32'(ctrl_changed[0]), 32'd1);
    chk("lat_rreq", 32'(reset_req), 32'd1);
    step();
    chk("press_once", 32'(btn_press[0]), 32'd0);
    raw_keys[0] = 1'b1;
    repeat (D + 2) step();
    chk("rel_nopress", 32'(btn_press), 32'd0);
    chk("rel_level", 32'(controls[W-1]), 32'd0);

    // Short glitch is rejected.
    raw_keys[1] = 1'b0;
    repeat (D - 1) step();
    raw_keys[1] = 1'b1;
    repeat (D + 4) step();
    chk("glitch", 32'(controls), 32'd0);

    // Switch mapping across three players.
    raw_sw = 12'hA5C;
    repeat (D + 1) step();
    step();
    chk("sw_map", 32'(controls), 32'h0A14C);
    chk("sw_chg", 32'(ctrl_changed), 32'd7);
    step();
    chk("sw_chg_once", 32'(ctrl_changed), 32'd0);

    // Two players pressing on the same edge.
    raw_keys[2] = 1'b0;
    raw_keys[1] = 1'b0;
    repeat (D + 2) step();
    chk("dual_press", 32'(btn_press), 32'h06);
    chk("dual_chg", 32'(ctrl_changed), 32'h3);
    raw_keys = '1;
    repeat (D + 3) step();

    // Button held through a 2-cycle reset.
    raw_keys[0] = 1'b0;
    repeat (D + 4) step();
    rst = 1'b1;
    step();
    chk("rst_ctrl", 32'(controls), 32'd0);
    chk("rst_press", 32'(btn_press), 32'd0);
    step();
    rst = 1'b0;
    repeat (D + 1) step();
    chk("held_early", 32'(btn_press[0]), 32'd0);
    step();
    chk("held_press", 32'(btn_press[0]), 32'd1);
    step();

    // Reset mid-debounce discards the count.
    raw_keys[0] = 1'b1;
    repeat (D + 3) step();
    raw_keys[3] = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    raw_keys[3] = 1'b1;
    repeat (D + 3) step();
    chk("mid_rst", 32'(controls[2*W-2]), 32'd0);

    // Random toggling with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 7) == 0) raw_keys[i] = ~raw_keys[i];
      for (int i = 0; i < P * S; i++)
        if ($urandom_range(0, 9) == 0) raw_sw[i] = ~raw_sw[i];
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    raw_keys = '1;
    raw_sw = '0;
    repeat (D + 4) step();

`ifdef PLAYER_INPUT_AUTOREPEAT_EN
    raw_keys[5] = 1'b0;
    repeat (D + 2) step();
    chk("rep_first", 32'(btn_press[5]), 32'd1);
    for (int t = 1; t <= 20; t++) begin
      step();
      chk("rep_pulse", 32'(btn_press[5]),
          32'(t == 10 || t == 13 || t == 16 || t == 19));
    end
    raw_keys[5] = 1'b1;
    repeat (D + 8) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
